// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared requester indices, grant encoding and selection helpers
//            for the three-way writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    localparam int REQ_ALU    = 0;
    localparam int REQ_MEM    = 1;
    localparam int REQ_MULDIV = 2;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } wb_state_e;

    function automatic logic [1:0] fixed_pick(input logic [2:0] v);
        if (v[REQ_ALU])      return SEL_A;
        else if (v[REQ_MEM]) return SEL_B;
        else                 return SEL_C;
    endfunction

    // Scans last+1, last+2, last+3 (mod 3); the first valid requester wins.
    function automatic logic [1:0] rr_pick(input logic [2:0] v, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        idx   = last;
        pick  = SEL_A;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == SEL_C) ? SEL_A : idx + 2'd1;
            if (!found && v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux3to1.sv
`default_nettype none
// ============================================================================
// Module   : mux3to1
// Purpose  : 3-to-1 word selector (sel 0/1/2 -> d0/d1/d2, 3 -> zero).
// Revision : 1.0 - initial release
// ============================================================================
module mux3to1 #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter3.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter3
// Purpose  : Three-requester writeback arbiter with a one-entry output
//            register. Macro WB_ARB_RR_EN selects round-robin; otherwise A>B>C.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter3
    import wb_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req_valid,
    input  logic [DATA_W-1:0] req_data_a,
    input  logic [DATA_W-1:0] req_data_b,
    input  logic [DATA_W-1:0] req_data_c,
    input  logic [ADDR_W-1:0] req_rd_a,
    input  logic [ADDR_W-1:0] req_rd_b,
    input  logic [ADDR_W-1:0] req_rd_c,
    output logic [2:0]        req_ready,
    output logic [1:0]        grant_sel,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_rd
);

    wb_state_e         state_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [ADDR_W-1:0] wb_rd_q;
    logic [1:0]        grant_q;
    logic [1:0]        grant_d;
    logic [1:0]        win_sel;
    logic              any_req;
    logic              can_accept;
    logic              xfer;
    logic [DATA_W-1:0] data_sel;
    logic [ADDR_W-1:0] rd_sel;

`ifdef WB_ARB_RR_EN
    logic [1:0]        last_grant_q;
    assign win_sel = rr_pick(req_valid, last_grant_q);
`else
    assign win_sel = fixed_pick(req_valid);
`endif

    assign any_req    = |req_valid;
    assign can_accept = (state_q == ST_EMPTY) || wb_ready;

    // With no request the grant display holds; reset forces it to A.
    always_comb begin
        grant_d = grant_q;
        if (any_req) begin
            grant_d = win_sel;
        end
        grant_sel = rst ? SEL_A : grant_d;
    end

    always_comb begin
        req_ready = 3'b000;
        if (!rst && any_req && can_accept) begin
            req_ready = 3'b001 << win_sel;
        end
    end

    assign xfer = |(req_valid & req_ready);

    mux3to1 #(
        .WIDTH (DATA_W)
    ) u_data_mux (
        .sel_i (grant_sel),
        .d0_i  (req_data_a),
        .d1_i  (req_data_b),
        .d2_i  (req_data_c),
        .y_o   (data_sel)
    );

    always_comb begin
        case (grant_sel)
            SEL_B:   rd_sel = req_rd_b;
            SEL_C:   rd_sel = req_rd_c;
            default: rd_sel = req_rd_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            wb_data_q    <= '0;
            wb_rd_q      <= '0;
            grant_q      <= SEL_A;
`ifdef WB_ARB_RR_EN
            last_grant_q <= SEL_C;
`endif
        end else begin
            grant_q <= grant_sel;
            if (xfer) begin
                state_q      <= ST_FULL;
                wb_data_q    <= data_sel;
                wb_rd_q      <= rd_sel;
`ifdef WB_ARB_RR_EN
                last_grant_q <= win_sel;
`endif
            end else if (state_q == ST_FULL && wb_ready) begin
                state_q <= ST_EMPTY;
            end
        end
    end

    assign wb_valid = (state_q == ST_FULL);
    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter3.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter3
// Purpose  : Self-checking bench: fixed vector table, corner sequences and
//            randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter3;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid;
    logic [DW-1:0] da, db, dc;
    logic [AW-1:0] ra, rb, rc;
    logic [2:0]    req_ready;
    logic [1:0]    grant_sel;
    logic          wb_valid;
    logic          wb_ready;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] wb_rd;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    bit            m_full;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_rd;
    int            m_last;
    int            m_gprev;

    typedef struct {
        bit         rst;
        logic [2:0] v;
        bit         wbr;
        logic [2:0] ready;
        logic [1:0] grant;
        bit         wbv;
        logic [31:0] data;
        logic [4:0] rd;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    wb_arbiter3 #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data_a (da),
        .req_data_b (db),
        .req_data_c (dc),
        .req_rd_a   (ra),
        .req_rd_b   (rb),
        .req_rd_c   (rc),
        .req_ready  (req_ready),
        .grant_sel  (grant_sel),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd)
    );

    function automatic int pick(input logic [2:0] v);
`ifdef WB_ARB_RR_EN
        for (int k = 1; k <= 3; k++) begin
            if (v[(m_last + k) % 3]) return (m_last + k) % 3;
        end
`else
        for (int i = 0; i < 3; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Wait to mid-cycle and optionally compare every output with the model.
    task automatic settle(input bit use_model);
        int w;
        bit can;
        logic [2:0] er;
        int eg;
        w   = pick(req_valid);
        can = !m_full || wb_ready;
        eg  = rst ? 0 : ((w >= 0) ? w : m_gprev);
        er  = (!rst && w >= 0 && can) ? (3'b001 << w) : 3'b000;
        #3;
        if (use_model) begin
            chk("mdl_ready", 64'(req_ready), 64'(er));
            chk("mdl_grant", 64'(grant_sel), 64'(eg));
            chk("mdl_wbv",   64'(wb_valid),  64'(m_full));
            chk("mdl_data",  64'(wb_data),   64'(m_data));
            chk("mdl_rd",    64'(wb_rd),     64'(m_rd));
        end
    endtask

    task automatic edge_step();
        int w;
        bit can;
        w   = pick(req_valid);
        can = !m_full || wb_ready;
        if (rst) begin
            m_full = 0; m_data = '0; m_rd = '0; m_last = 2; m_gprev = 0;
        end else begin
            if (w >= 0) m_gprev = w;
            if (w >= 0 && can) begin
                m_full = 1;
                m_data = (w == 0) ? da : (w == 1) ? db : dc;
                m_rd   = (w == 0) ? ra : (w == 1) ? rb : rc;
                m_last = w;
            end else if (m_full && wb_ready) begin
                m_full = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input logic [2:0] v, input bit wbr);
        rst = r; req_valid = v; wb_ready = wbr;
    endtask

    initial begin
        logic [1:0]    eg;
        logic [DW-1:0] held;

        tbl[0] = '{1'b1, 3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 32'h0,         5'd0};
        tbl[1] = '{1'b0, 3'b001, 1'b1, 3'b001, 2'd0, 1'b0, 32'h0,         5'd0};
        tbl[2] = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd0, 1'b1, 32'h0000000F,  5'd3};
        tbl[3] = '{1'b0, 3'b010, 1'b0, 3'b000, 2'd1, 1'b1, 32'h0000000F,  5'd3};
        tbl[4] = '{1'b0, 3'b010, 1'b1, 3'b010, 2'd1, 1'b1, 32'h0000000F,  5'd3};
        tbl[5] = '{1'b0, 3'b000, 1'b1, 3'b000, 2'd1, 1'b1, 32'hBBBB0001,  5'd7};
        tbl[6] = '{1'b0, 3'b100, 1'b0, 3'b100, 2'd2, 1'b0, 32'hBBBB0001,  5'd7};
        tbl[7] = '{1'b0, 3'b000, 1'b1, 3'b000, 2'd2, 1'b1, 32'hCCCC0002,  5'd17};
        tbl[8] = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd2, 1'b0, 32'hCCCC0002,  5'd17};

        da = 32'h0000000F; ra = 5'd3;
        db = 32'hBBBB0001; rb = 5'd7;
        dc = 32'hCCCC0002; rc = 5'd17;
        m_full = 0; m_data = '0; m_rd = '0; m_last = 2; m_gprev = 0;

        // First reset cycle brings the DUT out of its unknown power-up state.
        @(posedge clk); #1;
        drive(1'b1, 3'b111, 1'b1);
        settle(1'b0);
        edge_step();

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].wbr);
            settle(1'b1);
            chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].ready));
            chk($sformatf("tbl%0d_grant", i), 64'(grant_sel), 64'(tbl[i].grant));
            chk($sformatf("tbl%0d_wbv",   i), 64'(wb_valid),  64'(tbl[i].wbv));
            chk($sformatf("tbl%0d_data",  i), 64'(wb_data),   64'(tbl[i].data));
            chk($sformatf("tbl%0d_rd",    i), 64'(wb_rd),     64'(tbl[i].rd));
            edge_step();
        end

        // Full contention: one write per cycle in grant order.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 3'b111, 1'b1);
            settle(1'b1);
`ifdef WB_ARB_RR_EN
            eg = 2'(i % 3);
`else
            eg = 2'd0;
`endif
            chk($sformatf("cont%0d_grant", i), 64'(grant_sel), 64'(eg));
            chk($sformatf("cont%0d_ready", i), 64'(req_ready), 64'(3'b001 << eg));
            edge_step();
            chk($sformatf("cont%0d_wbv", i), 64'(wb_valid), 64'd1);
            chk($sformatf("cont%0d_rd", i), 64'(wb_rd),
                64'((eg == 2'd0) ? ra : (eg == 2'd1) ? rb : rc));
        end
`ifdef WB_ARB_RR_EN
        held = dc;
`else
        held = da;
`endif

        // Backpressure: B waits while the sink stalls, then goes in at once.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'b010, 1'b0);
            settle(1'b1);
            chk($sformatf("bp%0d_ready", i), 64'(req_ready), 64'd0);
            chk($sformatf("bp%0d_data", i), 64'(wb_data), 64'(held));
            edge_step();
        end
        drive(1'b0, 3'b010, 1'b1);
        settle(1'b1);
        chk("bp_release_ready", 64'(req_ready), 64'(3'b010));
        edge_step();
        drive(1'b0, 3'b000, 1'b1);
        settle(1'b1);
        chk("bp_release_data", 64'(wb_data), 64'(db));
        edge_step();

        // Reset during a stall discards contents and restarts priority at A.
        drive(1'b0, 3'b001, 1'b0);
        settle(1'b1);
        edge_step();
        drive(1'b0, 3'b000, 1'b0);
        settle(1'b1);
        chk("msr_full", 64'(wb_valid), 64'd1);
        edge_step();
        drive(1'b1, 3'b111, 1'b0);
        settle(1'b1);
        chk("msr_rst_ready", 64'(req_ready), 64'd0);
        chk("msr_rst_grant", 64'(grant_sel), 64'd0);
        edge_step();
        drive(1'b0, 3'b111, 1'b1);
        settle(1'b1);
        chk("msr_wbv", 64'(wb_valid), 64'd0);
        chk("msr_grant", 64'(grant_sel), 64'd0);
        chk("msr_ready", 64'(req_ready), 64'(3'b001));
        edge_step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            req_valid = 3'($urandom);
            wb_ready  = ($urandom_range(0, 3) != 0);
            da = $urandom; db = $urandom; dc = $urandom;
            ra = 5'($urandom); rb = 5'($urandom); rc = 5'($urandom);
            settle(1'b1);
            edge_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter3.md
WB_ARBITER3 -- requirements
Module: wb_arbiter3

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the width of the writeback data word.
REQ-002 SHALL have parameter ADDR_W, default 5, the width of the destination register index.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 3 bits: per-requester valid; bit0=ALU, bit1=MEM, bit2=MULDIV.
REQ-006 SHALL have ports req_data_a/b/c, input, DATA_W each: requester data words.
REQ-007 SHALL have ports req_rd_a/b/c, input, ADDR_W each: requester destination indices.
REQ-008 SHALL have port req_ready, output, 3 bits: per-requester accept strobe.
REQ-009 SHALL have port grant_sel, output, 2 bits: current grant; 00=A, 01=B, 10=C, never 11.
REQ-010 SHALL have port wb_valid, output, 1 bit: the output register holds a write.
REQ-011 SHALL have port wb_ready, input, 1 bit: register-file sink accepts the write.
REQ-012 SHALL have port wb_data, output, DATA_W: registered write data.
REQ-013 SHALL have port wb_rd, output, ADDR_W: registered write index.

Function
REQ-014 SHALL implement a two-state FSM: EMPTY (wb_valid=0) and FULL (wb_valid=1).
REQ-015 SHALL define "can accept" as state EMPTY, or state FULL with wb_ready=1.
REQ-016 SHALL select exactly one winner among asserted req_valid bits each cycle, combinationally, and drive grant_sel with it.
REQ-017 SHALL, when no req_valid is set, hold grant_sel at its previous value and assert no req_ready bit.
REQ-018 SHALL assert req_ready only for the winner, and only while "can accept"; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-019 SHALL capture the winner's data and rd into wb_data/wb_rd on a transfer; wb_valid rises on the next edge (1-cycle latency).
REQ-020 SHALL go FULL to EMPTY when wb_ready=1 and there is no transfer; stay FULL with new contents when wb_ready=1 and there is a transfer (back-to-back, 1 write/cycle).
REQ-021 SHALL keep wb_data/wb_rd/wb_valid stable while FULL and wb_ready=0.
REQ-022 SHALL compute priority with a round-robin pointer last_grant (0..2); search order is last_grant+1, +2, +3, mod 3.
REQ-023 SHALL update last_grant only on a transfer, never on an idle or stalled cycle.
REQ-024 SHALL ignore wb_ready while EMPTY.
REQ-025 SHALL leave requester payloads unchanged; rd=0 is forwarded like any other index.

Reset
REQ-026 SHALL, while rst=1 at an edge, set the state to EMPTY, wb_valid=0, wb_data=0, wb_rd=0, last_grant=2, and grant_sel=00.
REQ-027 SHALL force req_ready=000 during the reset cycle, and SHALL discard any in-flight FULL contents on reset.

Configuration
REQ-028 SHALL support macro WB_ARB_RR_EN: when defined, apply round-robin per REQ-022/023; when undefined, apply fixed priority A>B>C, with last_grant removed and grant_sel following the fixed winner.

Structure
REQ-029 SHALL place requester index constants (ALU=0, MEM=1, MULDIV=2) and the 2-bit select encoding in the shared package wb_arb_pkg.
REQ-030 SHALL produce the captured data through one instance of the existing 32-bit 3-to-1 selector mux3to1, driven by grant_sel; rd uses an internal equivalent select.

Verification
REQ-031 Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=000, wb_valid=0, grant_sel=00.
REQ-032 Single request: A valid, data 0x0000000F, rd=3, wb_ready=1 -> next cycle wb_valid=1, wb_data=0x0000000F, wb_rd=3.
REQ-033 Contention, RR build: req_valid=111 held for 6 cycles, wb_ready=1 -> grant order A,B,C,A,B,C with one write per cycle.
REQ-034 Backpressure: FULL with wb_ready=0 for 4 cycles while B valid -> req_ready=000 and wb_data held; wb_ready=1 -> B is accepted the same cycle.
REQ-035 Fixed build (WB_ARB_RR_EN undefined): req_valid=111 for 3 cycles -> A granted every cycle; B and C starve.
REQ-036 Mid-stall reset: FULL with wb_ready=0, assert rst -> next cycle wb_valid=0 and the next grant with req_valid=111 goes to A.
